axis_operand_splitter: RTL and testbench
========================================

Name: axis_operand_splitter

Overview:
- Source-side companion to the adder/subtractor AXIS control block.
- Takes one packed operand stream, where each beat is {A, B}, and splits it into two independent AXIS master streams. These drive the s_axis_a and s_axis_b slave ports of the arithmetic datapath.
- Each output has a one-deep output register, so the two consumers can stall independently without losing beat alignment.
- Keeps per-packet beat and packet counters for debug and status.

Parameters:
- DATA_W, 32: width of each operand (signed fixed-point, passed through unmodified).
- CNT_W, 16: width of the beat, packet and length counters.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset. Asserts immediately, releases synchronously to clk.
- s_axis_op_tdata  in  2*DATA_W  packed operands: [2*DATA_W-1:DATA_W] = A, [DATA_W-1:0] = B.
- s_axis_op_tvalid  in  1  input beat valid.
- s_axis_op_tlast  in  1  last beat of packet.
- s_axis_op_tready  out  1  input accepted this cycle when tvalid && tready.
- m_axis_a_tdata  out  DATA_W  operand A.
- m_axis_a_tvalid  out  1  A output valid.
- m_axis_a_tlast  out  1  copy of input tlast.
- m_axis_a_tready  in  1  A consumer ready.
- m_axis_b_tdata  out  DATA_W  operand B.
- m_axis_b_tvalid  out  1  B output valid.
- m_axis_b_tlast  out  1  copy of input tlast.
- m_axis_b_tready  in  1  B consumer ready.
- beat_cnt  out  CNT_W  beats accepted so far in the current packet.
- pkt_cnt  out  CNT_W  completed packets since reset; wraps.
- last_pkt_len  out  CNT_W  beat count of the most recently completed packet.

Behaviour:
- Reset values: all tdata 0, all tvalid 0, all tlast 0, beat_cnt 0, pkt_cnt 0, last_pkt_len 0.
- s_axis_op_tready is 0 while rst_n is low; it is gated with rst_n.
- Per-output slot state is {data, last, valid} for A and for B.
- Slot X is free when !X_valid || (X_valid && m_axis_x_tready).
- s_axis_op_tready = rst_n && free_a && free_b. This is combinational from the output treadys; there is no combinational path from s_axis_op_tvalid to tready.
- Input accept (tvalid && tready):
  - Both slots load on the next edge: A slot gets the upper half, B slot gets the lower half.
  - Both slots take last = s_axis_op_tlast and valid = 1.
- A slot not loaded this cycle:
  - If its beat transfers (valid && tready), valid clears to 0.
  - Otherwise it holds data, last and valid.
  - Data is retained after drain; only valid drops.
- B slot follows the same rule, independently of A.
- Independent drain:
  - A may transfer while B is stalled, or the reverse.
  - The drained slot goes empty, and the next input beat waits until both slots are free.
  - The A and B streams therefore always carry the same beat index: no reordering and no skew beyond one beat.
- Latency is 1 cycle from input accept to both output tvalid.
- Throughput is 1 beat per cycle when both treadys are held high.
- If an output tready stays low, the upstream stall takes effect in the same cycle. Output data and last stay stable while valid && !tready (AXIS rule).
- Counters, updated on input accept only:
  - Non-last beat: beat_cnt <= beat_cnt + 1.
  - Last beat: last_pkt_len <= beat_cnt + 1, beat_cnt <= 0, pkt_cnt <= pkt_cnt + 1.
  - All counters wrap modulo 2^CNT_W with no saturation and no error flag.
  - A single-beat packet gives last_pkt_len = 1.
- Simultaneous events:
  - Output drain and input accept in the same cycle: the load takes priority, so valid stays 1 with the new data. Back-to-back transfer with no bubble is required.
  - Input tvalid while both slots are valid and both treadys are low: tready = 0 and nothing changes.
- Reset mid-operation:
  - In-flight beats are discarded and all valids clear immediately.
  - The partial packet count is lost; beat_cnt returns to 0.
  - No output is asserted until a fresh input accept after reset release.
- No internal state machine beyond the two slot valid bits. Legal slot states are {empty, empty}, {full, full}, {full, empty} and {empty, full}.

Test Plan:
- Reset, then stream 4 beats with both treadys = 1. Use {A, B} = {0x00000001, 0xFFFFFFFF}, {2, 3}, {4, 5}, {6, 7}, with tlast on beat 4.
  - Required: each beat appears on m_axis_a and m_axis_b one cycle after accept, back-to-back.
  - Required: tlast on beat 4 of both outputs; pkt_cnt = 1, last_pkt_len = 4, beat_cnt = 0.
- Hold m_axis_b_tready = 0 for 3 cycles while m_axis_a_tready = 1, input continuously valid.
  - Required: A transfers beat 1 only, then goes empty.
  - Required: B holds beat 1 stable; s_axis_op_tready = 0 until B drains.
  - Required: beat 2 then loads into both slots with no loss or duplication.
- Random independent treadys on A and B (about 50% each) over 1000 beats with random packet lengths 1..16.
  - Required: A and B sequences match the input halves in order.
  - Required: tlast positions match on both outputs; pkt_cnt equals the number of packets sent.
- Single-beat packets, 3 in a row.
  - Required: last_pkt_len = 1 after each; pkt_cnt increments 1, 2, 3.
- With CNT_W = 4, send a 17-beat packet.
  - Required: beat_cnt wraps 15 -> 0 mid-packet; last_pkt_len = 1 (17 mod 16).
- Assert rst_n = 0 while both slots are full mid-packet.
  - Required: tvalids drop immediately and s_axis_op_tready = 0 during reset; all counters 0.
  - Required: first output after release is the first beat accepted post-reset.

Source files
------------

// File: rtl/axis_operand_splitter.sv
//------------------------------------------------------------------------------
// axis_operand_splitter
//   Splits a packed {A, B} operand stream into two AXIS streams, each behind a
//   one-deep output slot, and tracks per-packet beat/packet counts.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axis_operand_splitter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*DATA_W-1:0] s_axis_op_tdata,
  input  logic                s_axis_op_tvalid,
  input  logic                s_axis_op_tlast,
  output logic                s_axis_op_tready,
  output logic [DATA_W-1:0]   m_axis_a_tdata,
  output logic                m_axis_a_tvalid,
  output logic                m_axis_a_tlast,
  input  logic                m_axis_a_tready,
  output logic [DATA_W-1:0]   m_axis_b_tdata,
  output logic                m_axis_b_tvalid,
  output logic                m_axis_b_tlast,
  input  logic                m_axis_b_tready,
  output logic [CNT_W-1:0]    beat_cnt,
  output logic [CNT_W-1:0]    pkt_cnt,
  output logic [CNT_W-1:0]    last_pkt_len
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic              a_last_q, a_last_d, b_last_q, b_last_d;
  logic              a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d, pkt_cnt_q, pkt_cnt_d, len_q, len_d;
  logic              free_a, free_b, accept;

  // A slot is free if empty or draining this cycle; tvalid never feeds tready.
  assign free_a           = !a_valid_q || m_axis_a_tready;
  assign free_b           = !b_valid_q || m_axis_b_tready;
  assign s_axis_op_tready = rst_n && free_a && free_b;
  assign accept           = s_axis_op_tvalid && s_axis_op_tready;

  always_comb begin
    a_data_d   = a_data_q;
    a_last_d   = a_last_q;
    a_valid_d  = a_valid_q;
    b_data_d   = b_data_q;
    b_last_d   = b_last_q;
    b_valid_d  = b_valid_q;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    len_d      = len_q;

    // Load wins over drain so back-to-back beats see no bubble.
    if (accept) begin
      a_data_d  = s_axis_op_tdata[2*DATA_W-1:DATA_W];
      b_data_d  = s_axis_op_tdata[DATA_W-1:0];
      a_last_d  = s_axis_op_tlast;
      b_last_d  = s_axis_op_tlast;
      a_valid_d = 1'b1;
      b_valid_d = 1'b1;
      if (s_axis_op_tlast) begin
        len_d      = beat_cnt_q + C_ONE;
        beat_cnt_d = '0;
        pkt_cnt_d  = pkt_cnt_q + C_ONE;
      end else begin
        beat_cnt_d = beat_cnt_q + C_ONE;
      end
    end else begin
      if (a_valid_q && m_axis_a_tready) a_valid_d = 1'b0;
      if (b_valid_q && m_axis_b_tready) b_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data_q   <= '0;
      a_last_q   <= 1'b0;
      a_valid_q  <= 1'b0;
      b_data_q   <= '0;
      b_last_q   <= 1'b0;
      b_valid_q  <= 1'b0;
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      len_q      <= '0;
    end else begin
      a_data_q   <= a_data_d;
      a_last_q   <= a_last_d;
      a_valid_q  <= a_valid_d;
      b_data_q   <= b_data_d;
      b_last_q   <= b_last_d;
      b_valid_q  <= b_valid_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      len_q      <= len_d;
    end
  end

  assign m_axis_a_tdata  = a_data_q;
  assign m_axis_a_tvalid = a_valid_q;
  assign m_axis_a_tlast  = a_last_q;
  assign m_axis_b_tdata  = b_data_q;
  assign m_axis_b_tvalid = b_valid_q;
  assign m_axis_b_tlast  = b_last_q;
  assign beat_cnt        = beat_cnt_q;
  assign pkt_cnt         = pkt_cnt_q;
  assign last_pkt_len    = len_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_operand_splitter.sv
//------------------------------------------------------------------------------
// tb_axis_operand_splitter
//   Directed and random scoreboard bench; a CNT_W=4 twin shares all inputs.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axis_operand_splitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0;
  logic        a_r = 1'b1, b_r = 1'b1;
  wire         s_tready, a_v, a_l, b_v, b_l;
  wire  [31:0] a_d, b_d;
  wire  [15:0] bcnt, pcnt, plen;
  wire         s_tready4, a_v4, a_l4, b_v4, b_l4;
  wire  [31:0] a_d4, b_d4;
  wire  [3:0]  bcnt4, pcnt4, plen4;

  int checks = 0, errors = 0;
  logic [32:0] qa[$], qb[$];
  logic [15:0] exp_beat = '0, exp_pkt = '0, exp_len = '0;
  bit          rnd = 1'b0;

  always #5 clk = ~clk;

  axis_operand_splitter #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_op_tdata(s_tdata), .s_axis_op_tvalid(s_tvalid), .s_axis_op_tlast(s_tlast),
    .s_axis_op_tready(s_tready),
    .m_axis_a_tdata(a_d), .m_axis_a_tvalid(a_v), .m_axis_a_tlast(a_l), .m_axis_a_tready(a_r),
    .m_axis_b_tdata(b_d), .m_axis_b_tvalid(b_v), .m_axis_b_tlast(b_l), .m_axis_b_tready(b_r),
    .beat_cnt(bcnt), .pkt_cnt(pcnt), .last_pkt_len(plen));

  axis_operand_splitter #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_op_tdata(s_tdata), .s_axis_op_tvalid(s_tvalid), .s_axis_op_tlast(s_tlast),
    .s_axis_op_tready(s_tready4),
    .m_axis_a_tdata(a_d4), .m_axis_a_tvalid(a_v4), .m_axis_a_tlast(a_l4), .m_axis_a_tready(a_r),
    .m_axis_b_tdata(b_d4), .m_axis_b_tvalid(b_v4), .m_axis_b_tlast(b_l4), .m_axis_b_tready(b_r),
    .beat_cnt(bcnt4), .pkt_cnt(pcnt4), .last_pkt_len(plen4));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on output transfer, then push on input accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_v && a_r) begin
        if (qa.size() == 0) chk("a_unexpected_beat", 1, 0);
        else chk("a_beat", {a_l, a_d}, qa.pop_front());
      end
      if (b_v && b_r) begin
        if (qb.size() == 0) chk("b_unexpected_beat", 1, 0);
        else chk("b_beat", {b_l, b_d}, qb.pop_front());
      end
      chk("twin_outputs", {s_tready4, a_v4, a_l4, a_d4, b_v4, b_l4, b_d4},
                          {s_tready, a_v, a_l, a_d, b_v, b_l, b_d});
      if (s_tvalid && s_tready) begin
        qa.push_back({s_tlast, s_tdata[63:32]});
        qb.push_back({s_tlast, s_tdata[31:0]});
      end
    end
  end

  task automatic check_counters();
    chk("beat_cnt", bcnt, exp_beat);
    chk("pkt_cnt", pcnt, exp_pkt);
    chk("last_pkt_len", plen, exp_len);
    chk("cnt4", {bcnt4, pcnt4, plen4}, {exp_beat[3:0], exp_pkt[3:0], exp_len[3:0]});
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last,
                      output int stalls);
    s_tdata = {a, b}; s_tlast = last; s_tvalid = 1'b1;
    stalls = 0;
    if (rnd) begin a_r = $urandom_range(0, 1); b_r = $urandom_range(0, 1); end
    forever begin
      @(negedge clk);
      if (s_tready) break;
      stalls++;
      if (stalls >= 200) begin chk("accept_timeout", 0, 1); break; end
      @(posedge clk); #1;
      if (rnd) begin a_r = $urandom_range(0, 1); b_r = $urandom_range(0, 1); end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    if (last) begin exp_len = exp_beat + 16'd1; exp_beat = '0; exp_pkt = exp_pkt + 16'd1; end
    else exp_beat = exp_beat + 16'd1;
    check_counters();
  endtask

  task automatic drain();
    int n;
    a_r = 1'b1; b_r = 1'b1; s_tvalid = 1'b0;
    n = 0;
    while ((qa.size() + qb.size() != 0) && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    chk("drain_empty", qa.size() + qb.size(), 0);
    chk("drained_valids", {a_v, b_v}, 2'b00);
  endtask

  initial begin
    int st, len;
    logic [31:0] av[4], bv[4];
    av = '{32'h1, 32'h2, 32'h4, 32'h6};
    bv = '{32'hFFFF_FFFF, 32'h3, 32'h5, 32'h7};

    #3;
    chk("reset_outputs", {s_tready, a_v, a_l, a_d, b_v, b_l, b_d, bcnt, pcnt, plen}, '0);
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_tready", s_tready, 1);

    // Four back-to-back beats, both consumers ready
    for (int i = 0; i < 4; i++) begin
      send(av[i], bv[i], i == 3, st);
      chk("t1_no_stall", st, 0);
      chk("t1_latency", {a_v, a_l, a_d, b_v, b_l, b_d},
          {1'b1, i == 3, av[i], 1'b1, i == 3, bv[i]});
    end
    chk("t1_counts", {pcnt, plen, bcnt}, {16'd1, 16'd4, 16'd0});
    drain();

    // B stalled for 3 cycles while A drains
    send(32'hA1, 32'hB1, 1'b0, st);
    b_r = 1'b0;
    s_tdata = {32'hA2, 32'hB2}; s_tlast = 1'b0; s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_tready_low", s_tready, 0);
      chk("t2_b_hold", {b_v, b_d}, {1'b1, 32'hB1});
      chk("t2_a_state", a_v, i == 0);
      @(posedge clk); #1;
    end
    b_r = 1'b1;
    send(32'hA2, 32'hB2, 1'b1, st);
    chk("t2_beat2_loaded", {a_v, a_d, b_v, b_d}, {1'b1, 32'hA2, 1'b1, 32'hB2});
    drain();

    // Random independent backpressure
    rnd = 1'b1;
    begin
      int sent, pkts_before;
      sent = 0;
      pkts_before = exp_pkt;
      while (sent < 1000) begin
        len = $urandom_range(1, 16);
        for (int k = 0; k < len; k++) begin
          send($urandom, $urandom, k == len - 1, st);
          sent++;
        end
      end
      rnd = 1'b0;
      drain();
      chk("rnd_pkt_progress", pcnt > 16'(pkts_before), 1);
    end

    // Three single-beat packets
    for (int i = 0; i < 3; i++) begin
      logic [15:0] p0;
      p0 = exp_pkt;
      send(32'hC0 + i, 32'hD0 + i, 1'b1, st);
      chk("single_len", plen, 16'd1);
      chk("single_pkt_inc", pcnt, p0 + 16'd1);
    end
    drain();

    // 17-beat packet: the 4-bit twin wraps mid-packet
    for (int i = 0; i < 17; i++) begin
      send(32'h100 + i, 32'h200 + i, i == 16, st);
      if (i == 15) chk("wrap_beat_cnt4", bcnt4, 4'd0);
    end
    chk("len17", {plen, plen4}, {16'd17, 4'd1});
    drain();

    // Reset with both slots full mid-packet
    a_r = 1'b0; b_r = 1'b0;
    send(32'hE1, 32'hF1, 1'b0, st);
    s_tdata = {32'hE2, 32'hF2}; s_tvalid = 1'b1;
    @(negedge clk);
    chk("pre_reset_full", {a_v, b_v, s_tready}, 3'b110);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {s_tready, a_v, b_v, bcnt, pcnt, plen, bcnt4, pcnt4, plen4}, '0);
    qa.delete(); qb.delete();
    exp_beat = '0; exp_pkt = '0; exp_len = '0;
    @(posedge clk); #1;
    chk("reset_hold", {s_tready, a_v, b_v}, 3'b000);
    s_tvalid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_release_idle", {a_v, b_v}, 2'b00);
    a_r = 1'b1; b_r = 1'b1;
    send(32'h5A5A, 32'hA5A5, 1'b1, st);
    chk("post_reset_first", {a_v, a_d, b_v, b_d}, {1'b1, 32'h5A5A, 1'b1, 32'hA5A5});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
